// File: rtl/fnd_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment vectors are active-low {a,b,c,d,e,f,g}; commons are active-low.
package fnd_pkg;

  localparam int unsigned N_DIG = 6;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [5:0] COM_OFF  = 6'b111111;
  localparam logic       DP_OFF   = 1'b1;

  // Entry n is the pattern for BCD digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h04, 7'h00, 7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  // Bit k set when digit k and every digit to its left are zero; the rightmost never blanks.
  function automatic logic [N_DIG-1:0] lead_zero_mask(input logic [N_DIG-1:0][3:0] dig);
    logic [N_DIG-1:0] mask;
    logic             run;
    mask = '0;
    run  = 1'b1;
    for (int k = 0; k < N_DIG - 1; k++) begin
      run     = run && (dig[k] == 4'd0);
      mask[k] = run;
    end
    return mask;
  endfunction

endpackage

// File: rtl/fnd_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 show a dash.
module fnd_bcd_to_seg
  import fnd_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (bcd_i <= 4'd9) seg_o = SEG_TABLE[bcd_i];
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// Six-digit common-anode scan driver with per-scan frame latching and anti-ghost blanking.
// Optional leading-zero suppression is enabled by defining FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned SCAN_HZ   = 6_000,
  parameter int unsigned BLANK_CYC = 500,
  parameter logic [5:0]  DP_MASK   = 6'b010100
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       en_i,
  input  logic [3:0] d_i,
  input  logic [3:0] e_i,
  input  logic [3:0] f_i,
  input  logic [3:0] g_i,
  input  logic [3:0] h_i,
  input  logic [3:0] i_i,
  output logic [5:0] com_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);

  localparam int unsigned Div  = CLK_HZ / SCAN_HZ;
  localparam int unsigned PscW = $clog2(Div);

  logic [PscW-1:0]            psc_q, psc_d;
  logic [2:0]                 idx_q, idx_d;
  logic [N_DIG-1:0][3:0]      frame_q, frame_d;
  logic [5:0]                 com_q, com_d;
  logic [6:0]                 seg_q, seg_d;
  logic                       dp_q, dp_d;
  logic [N_DIG-1:0][3:0]      din;
  logic                       tick, wrap, lit, dig_blank;
  logic [6:0]                 dec_seg;

  // Index 0 is the leftmost digit (d).
  assign din  = {i_i, h_i, g_i, f_i, e_i, d_i};
  assign tick = en_i && (psc_q == PscW'(Div - 1));
  assign wrap = tick && (idx_q == 3'(N_DIG - 1));
  assign lit  = psc_q >= PscW'(BLANK_CYC);

  fnd_bcd_to_seg u_dec (
    .bcd_i (frame_q[idx_q]),
    .seg_o (dec_seg)
  );

`ifdef FND_LEADING_ZERO_BLANK_EN
  logic [N_DIG-1:0] lz_q, lz_d;

  assign lz_d      = wrap ? lead_zero_mask(din) : lz_q;
  assign dig_blank = lz_q[idx_q];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) lz_q <= '0;
    else           lz_q <= lz_d;
  end
`else
  assign dig_blank = 1'b0;
`endif

  always_comb begin
    psc_d   = psc_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    if (en_i) psc_d = tick ? '0 : psc_q + PscW'(1);
    if (tick) idx_d = wrap ? 3'd0 : idx_q + 3'd1;
    if (wrap) frame_d = din;
  end

  // Outputs reflect the state seen at this edge, so they lag the counters by one clock.
  always_comb begin
    com_d = COM_OFF;
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    if (en_i) begin
      seg_d = dig_blank ? SEG_OFF : dec_seg;
      if (lit) begin
        com_d = COM_OFF ^ (6'b100000 >> idx_q);
        dp_d  = ~DP_MASK[3'd5 - idx_q];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      psc_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      com_q   <= COM_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
    end else begin
      psc_q   <= psc_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      com_q   <= com_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign com_o = com_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver with DIV=10, BLANK_CYC=2 and a 20 ns clock.
module tb_fnd_scan_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b1;
  logic [3:0] d = 4'd0, e = 4'd0, f = 4'd0, g = 4'd0, h = 4'd0, i = 4'd0;
  logic [5:0] com;
  logic [6:0] seg;
  logic       dp;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int k = 0;

  // Independent active-low {a..g} expectations.
  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000, S9 = 7'b0000100, SDASH = 7'b1111110;
  localparam logic [6:0] SDARK = 7'b1111111;
`ifdef FND_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SLZ = SDARK;
`else
  localparam logic [6:0] SLZ = S0;
`endif

  always #10 clk = ~clk;

  fnd_scan_driver #(
    .CLK_HZ    (1000),
    .SCAN_HZ   (100),
    .BLANK_CYC (2),
    .DP_MASK   (6'b010100)
  ) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .en_i     (en),
    .d_i      (d),
    .e_i      (e),
    .f_i      (f),
    .g_i      (g),
    .h_i      (h),
    .i_i      (i),
    .com_o    (com),
    .seg_o    (seg),
    .dp_o     (dp)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] c, input logic [6:0] s,
                         input logic p);
    chk({tag, ".com"}, {2'b0, com}, {2'b0, c});
    chk({tag, ".seg"}, {1'b0, seg}, {1'b0, s});
    chk({tag, ".dp"}, {7'b0, dp}, {7'b0, p});
  endtask

  // k counts falling edges since the last reset release; all drive/sample happens there.
  task automatic adv_to(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic set_dig(input logic [3:0] a0, a1, a2, a3, a4, a5);
    d = a0; e = a1; f = a2; g = a3; h = a4; i = a5;
  endtask

  initial begin
    // Reset held: outputs dark regardless of inputs.
    repeat (2) @(negedge clk);
    chk_out("rst_hold0", 6'h3F, SDARK, 1'b1);
    set_dig(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    repeat (2) @(negedge clk);
    chk_out("rst_hold1", 6'h3F, SDARK, 1'b1);
    reset_n = 1'b1;
    k = 0;

    // First slot: two blank clocks, then digit d lit from a zero frame.
    adv_to(1);  chk("blank1.com", {2'b0, com}, 8'h3F);
    adv_to(2);  chk("blank2.com", {2'b0, com}, 8'h3F);
    adv_to(3);  chk_out("first_lit", 6'b011111, S0, 1'b1);
    adv_to(12); chk("e_blank.com", {2'b0, com}, 8'h3F);
    adv_to(13); chk_out("e_zero", 6'b101111, S0, 1'b0);

    // Second frame shows the captured 1..6.
    adv_to(63);  chk_out("scan_d", 6'b011111, S1, 1'b1);
    adv_to(73);  chk_out("scan_e", 6'b101111, S2, 1'b0);
    adv_to(83);  chk_out("scan_f", 6'b110111, S3, 1'b1);
    adv_to(93);  chk_out("scan_g", 6'b111011, S4, 1'b0);
    adv_to(103); chk_out("scan_h", 6'b111101, S5, 1'b1);
    adv_to(113); chk_out("scan_i", 6'b111110, S6, 1'b1);
    adv_to(120); chk("i_end.com", {2'b0, com}, 8'h3E);
    adv_to(121); chk_out("wrap_blank", 6'h3F, S1, 1'b1);

    // Coherency: inputs change in f's slot, old frame persists until the wrap.
    adv_to(143);
    set_dig(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
    adv_to(145); chk("coh_f.seg", {1'b0, seg}, {1'b0, S3});
    adv_to(153); chk("coh_g.seg", {1'b0, seg}, {1'b0, S4});
    adv_to(173); chk("coh_i.seg", {1'b0, seg}, {1'b0, S6});
    adv_to(183); chk_out("new_d", 6'b011111, S9, 1'b1);
    adv_to(193); chk("new_e.seg", {1'b0, seg}, {1'b0, S9});

    // Invalid BCD in g, decimal points only in e and g.
    set_dig(4'd1, 4'd2, 4'd3, 4'hC, 4'd5, 4'd6);
    adv_to(253); chk_out("inv_e", 6'b101111, S2, 1'b0);
    adv_to(263); chk_out("inv_f", 6'b110111, S3, 1'b1);
    adv_to(271); chk_out("inv_gblank", 6'h3F, SDASH, 1'b1);
    adv_to(273); chk_out("inv_g", 6'b111011, SDASH, 1'b0);
    adv_to(283); chk_out("inv_h", 6'b111101, S5, 1'b1);

    // Pause for 25 clocks in the middle of h's slot.
    adv_to(285);
    en = 1'b0;
    adv_to(286); chk_out("pause_dark", 6'h3F, SDARK, 1'b1);
    adv_to(300); chk_out("pause_mid", 6'h3F, SDARK, 1'b1);
    adv_to(310);
    en = 1'b1;
    adv_to(311); chk_out("resume_h", 6'b111101, S5, 1'b1);
    adv_to(315); chk("resume_hend.com", {2'b0, com}, 8'h3D);
    adv_to(316); chk("resume_iblank.com", {2'b0, com}, 8'h3F);
    adv_to(318); chk_out("resume_i", 6'b111110, S6, 1'b1);

    // Leading zeros: 0,0,1,0,0,0 then all zeros.
    set_dig(4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0);
    adv_to(328); chk_out("lz_d", 6'b011111, SLZ, 1'b1);
    adv_to(338); chk_out("lz_e", 6'b101111, SLZ, 1'b0);
    adv_to(348); chk("lz_f.seg", {1'b0, seg}, {1'b0, S1});
    adv_to(358); chk("lz_g.seg", {1'b0, seg}, {1'b0, S0});
    adv_to(378); chk("lz_i.seg", {1'b0, seg}, {1'b0, S0});
    set_dig(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    adv_to(388); chk("z_d.seg", {1'b0, seg}, {1'b0, SLZ});
    adv_to(428); chk("z_h.seg", {1'b0, seg}, {1'b0, SLZ});
    adv_to(438); chk_out("z_i", 6'b111110, S0, 1'b1);

    // Asynchronous reset mid-scan, then a zero frame until the first wrap.
    reset_n = 1'b0;
    #1;
    chk_out("midrst", 6'h3F, SDARK, 1'b1);
    set_dig(4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7);
    @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    adv_to(2);  chk("post_rst_blank.com", {2'b0, com}, 8'h3F);
    adv_to(3);  chk_out("post_rst_d", 6'b011111, S0, 1'b1);
    adv_to(13); chk_out("post_rst_e", 6'b101111, S0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
